// File: rtl/matrix_column_scanner_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared helpers for the LED-matrix scan blocks (column scanner, row driver).
//   num_phases  : number of unique scan phases for a column count / mirror mode
//   index_width : width of a binary phase index (never less than 1)
//   mirror_map  : which scan phase drives a given physical column
// -----------------------------------------------------------------------------
package matrix_pkg;

    // With mirroring, column i and column COLS-1-i share one phase, so only
    // the left half (plus the centre column for odd counts) needs a phase.
    function automatic int num_phases(input int cols, input int mirror);
        return (mirror != 0) ? (cols + 1) / 2 : cols;
    endfunction

    function automatic int index_width(input int u);
        return (u <= 1) ? 1 : $clog2(u);
    endfunction

    function automatic int mirror_map(input int c, input int cols, input int mirror);
        if (mirror == 0) begin
            return c;
        end
        return (c < (cols - 1 - c)) ? c : (cols - 1 - c);
    endfunction

endpackage

// File: rtl/matrix_column_scanner_if.sv
// -----------------------------------------------------------------------------
// matrix_column_scanner_if
// Control inputs and scan outputs of the column scanner.
//   enable, restart, blank           : controller -> scanner
//   phase, col, col_index,
//   frame_start, fault               : scanner -> controller / column drivers
// master = controller side, slave = scanner side.
// -----------------------------------------------------------------------------
interface matrix_column_scanner_if #(
    parameter int COLS = 5,
    parameter int U    = 3,
    parameter int IW   = 2
);
    logic            enable;
    logic            restart;
    logic            blank;
    logic [U-1:0]    phase;
    logic [COLS-1:0] col;
    logic [IW-1:0]   col_index;
    logic            frame_start;
    logic            fault;

    modport master (
        output enable, restart, blank,
        input  phase, col, col_index, frame_start, fault
    );

    modport slave (
        input  enable, restart, blank,
        output phase, col, col_index, frame_start, fault
    );
endinterface

// File: rtl/matrix_column_scanner_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Dwell counter: counts enabled clocks 0..DWELL-1 and pulses tick on the last.
//   clock  : scan clock
//   reset  : asynchronous, active-high
//   enable : count this clock
//   clear  : synchronous return to 0, wins over enable
//   tick   : combinational, enable && count == DWELL-1
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DWELL = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = enable && (cnt_q == CW'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/matrix_column_scanner.sv
// -----------------------------------------------------------------------------
// matrix_column_scanner
// One-hot ring counter that walks the column drive of an LED matrix.
//   clock : scan clock, rising edge
//   reset : asynchronous, active-high; returns to phase 0
//   bus   : slave side of matrix_column_scanner_if
//           enable/restart/blank in; phase/col/col_index/frame_start/fault out
// Parameters: COLS physical columns, MIRROR folds column i onto COLS-1-i,
// DWELL clocks each phase stays active while enabled.
// -----------------------------------------------------------------------------
module matrix_column_scanner
    import matrix_pkg::*;
#(
    parameter int COLS   = 5,
    parameter int MIRROR = 1,
    parameter int DWELL  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    matrix_column_scanner_if.slave  bus
);
    localparam int           U      = num_phases(COLS, MIRROR);
    localparam int           IW     = index_width(U);
    localparam logic [U-1:0] PHASE0 = U'(1);

    logic [U-1:0]  phase_q;
    logic [U-1:0]  phase_d;
    logic          frame_start_q;
    logic          frame_start_d;
    logic          fault_q;
    logic          fault_d;
    logic [U-1:0]  phase_rot;
    logic [IW-1:0] col_index_c;
    logic          legal;
    logic          tick;

    assign legal = $onehot(phase_q);

    // An illegal phase also restarts the dwell so phase 0 gets a full dwell.
    scan_prescaler #(
        .DWELL (DWELL)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .clear  (bus.restart || !legal),
        .tick   (tick)
    );

    // Rotation written as a loop so a single-phase ring (U == 1) still works.
    always_comb begin
        phase_rot = '0;
        for (int k = 0; k < U; k++) begin
            phase_rot[(k + 1) % U] = phase_q[k];
        end
    end

    // Recovery from a corrupted ring outranks restart and does not count as
    // a frame start; restart outranks a coincident tick.
    always_comb begin
        phase_d       = phase_q;
        frame_start_d = 1'b0;
        fault_d       = fault_q;
        if (!legal) begin
            phase_d = PHASE0;
            fault_d = 1'b1;
        end else if (bus.restart) begin
            phase_d       = PHASE0;
            frame_start_d = 1'b1;
        end else if (tick) begin
            phase_d       = phase_rot;
            frame_start_d = phase_q[U-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q       <= PHASE0;
            frame_start_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            frame_start_q <= frame_start_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        col_index_c = '0;
        for (int k = 0; k < U; k++) begin
            if (phase_q[k]) begin
                col_index_c = col_index_c | IW'(k);
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign bus.col[c] = phase_q[mirror_map(c, COLS, MIRROR)] & ~bus.blank;
    end

    assign bus.phase       = phase_q;
    assign bus.col_index   = col_index_c;
    assign bus.frame_start = frame_start_q;
    assign bus.fault       = fault_q;
endmodule

// File: doc/matrix_column_scanner.md
MATRIX_COLUMN_SCANNER -- requirements
Module: matrix_column_scanner

Interface
REQ-001 SHALL have parameter COLS, default 5, number of physical matrix columns (>=2).
REQ-002 SHALL have parameter MIRROR, default 1: 1 = columns i and COLS-1-i share one scan phase; 0 = every column has its own phase.
REQ-003 SHALL have parameter DWELL, default 1: clocks each phase stays active while enabled (>=1).
REQ-004 SHALL define U = MIRROR ? ceil(COLS/2) : COLS unique phases, and IW = max(1, clog2(U)).
REQ-005 SHALL have port clock  input  1  single scan clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  advances the dwell counter when high; freezes all scan state when low.
REQ-008 SHALL have port restart  input  1  synchronous return to phase 0.
REQ-009 SHALL have port blank  input  1  forces col to all-zero without stopping the scan.
REQ-010 SHALL have port phase  output  U  one-hot ring-counter state.
REQ-011 SHALL have port col  output  COLS  expanded column drive: col[i] = phase[min(i, COLS-1-i)] if MIRROR, else phase[i]; AND with !blank.
REQ-012 SHALL have port col_index  output  IW  binary index of the active phase.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse, registered, high in the first cycle phase[0] becomes active.
REQ-014 SHALL have port fault  output  1  sticky flag set when an illegal (non-one-hot) phase is detected.

Function
REQ-015 SHALL hold a dwell counter 0..DWELL-1; tick = enable && counter==DWELL-1; on enable without tick, counter increments; on tick, counter clears.
REQ-016 SHALL, on tick, rotate phase: phase[k] -> phase[k+1], phase[U-1] -> phase[0]; wrap-around from U-1 to 0 SHALL assert frame_start in the following cycle (aligned with phase[0]).
REQ-017 SHALL, when enable is low, hold phase, counter and col_index; frame_start SHALL be 0.
REQ-018 SHALL, when restart is high, load phase = one-hot bit 0, clear counter, assert frame_start next cycle; restart SHALL take priority over enable and tick.
REQ-019 SHALL, when phase is not one-hot (zero or multiple bits), load phase 0 and clear counter at the next edge regardless of enable, set fault, and not assert frame_start.
REQ-020 SHALL clear fault only by reset.
REQ-021 SHALL make col and col_index combinational from phase (and blank); latency from tick to new col = 1 clock.
REQ-022 SHALL, for odd COLS with MIRROR=1, drive the centre column from phase[U-1] alone; for even COLS, phase[U-1] SHALL drive two columns.
REQ-023 SHALL, with DWELL=1 and enable held high, advance one phase every clock (full frame = U clocks).

Reset
REQ-024 SHALL, on reset assertion, immediately set phase = one-hot bit 0, counter = 0, frame_start = 0, fault = 0; col = col[0] (and col[COLS-1] if MIRROR) unless blank.
REQ-025 SHALL resume counting on the first rising edge after reset deasserts; reset mid-dwell SHALL discard the partial count.

Structure
REQ-026 SHALL place the U/IW derivation function and the mirror-map function in shared package matrix_pkg, for reuse by the row driver.
REQ-027 SHALL implement the dwell counter as sub-module scan_prescaler (parameter DWELL; ports clock, reset, enable, clear, tick).

Verification
REQ-028 Reset, COLS=5, MIRROR=1, DWELL=1, enable=1 -> phase 001,010,100,001; col 10001,01010,00100,10001; frame_start high at clocks 3,6.
REQ-029 COLS=5, MIRROR=0, DWELL=3 -> each of 5 columns high 3 clocks; col_index 0..4 then 0; frame period 15 clocks.
REQ-030 enable low for 4 clocks at phase 010, counter=1 -> phase, counter frozen; resumes with 1 clock remaining of dwell.
REQ-031 restart and tick same cycle at phase 100 -> next phase 001, frame_start=1, counter=0.
REQ-032 Force phase=011 -> next clock phase 001, fault=1, frame_start=0; fault stays 1 until reset.
REQ-033 COLS=6, MIRROR=1, blank=1 during phase 100 -> col 000000 while phase advances; blank=0 -> col 001100.
